// File: rtl/rom_fetch_ctrl_pkg.sv
// rom_fetch_ctrl_pkg: shared FSM encodings and instruction geometry for the ROM fetch controller
package rom_fetch_ctrl_pkg;
    localparam int INST_W = 32;
    localparam int LANES  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: one-entry instruction buffer refilled by four little-endian byte reads
module rom_fetch_ctrl
    import rom_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce,
    input  logic [ADDR_W-1:0] rom_raddr,
    output logic [INST_W-1:0] rom_rdata,
    output logic              stall,
    input  logic              flush,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);
    localparam int WA = ADDR_W - 2;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic              abort, abort_n, buf_valid, buf_valid_n, mem_re_n;
    logic [WA-1:0]     buf_addr, buf_addr_n, fetch_addr, fetch_addr_n, word;
    logic [INST_W-1:0] buf_data, buf_data_n, asm_q, asm_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              hit, cancel, unused_lo;

    assign word      = rom_raddr[ADDR_W-1:2];
    assign unused_lo = ^rom_raddr[1:0];
    assign hit       = rom_ce && buf_valid && word == buf_addr && !flush;
    assign stall     = rom_ce && !hit;
    assign rom_rdata = buf_data;
    assign cancel    = flush || !rom_ce || word != fetch_addr;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        abort_n      = abort;
        fetch_addr_n = fetch_addr;
        buf_valid_n  = buf_valid;
        buf_addr_n   = buf_addr;
        buf_data_n   = buf_data;
        asm_n        = asm_q;
        case (state)
            IDLE: begin
                abort_n = 1'b0;
                if (rom_ce && !hit) begin
                    fetch_addr_n = word;
                    idx_n        = 2'd0;
                    state_n      = REQ;
                end
            end
            REQ: begin
                abort_n = abort || cancel;
                state_n = abort ? IDLE : WAIT;
            end
            WAIT: begin
                abort_n = abort || cancel;
                if (mem_rvalid) begin
                    asm_n[8*idx +: 8] = mem_rdata;
                    if (abort) state_n = IDLE;
                    else if (idx == 2'(LANES - 1)) begin
                        state_n = IDLE;
                        // a coincident flush discards the finished word
                        if (!flush) begin
                            buf_valid_n = 1'b1;
                            buf_addr_n  = fetch_addr;
                            buf_data_n  = asm_n;
                        end
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) buf_valid_n = 1'b0;
        mem_re_n   = state_n == REQ && !abort_n;
        mem_addr_n = mem_re_n ? {fetch_addr_n, idx_n} : mem_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            abort      <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            fetch_addr <= '0;
            asm_q      <= '0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            abort      <= abort_n;
            buf_valid  <= buf_valid_n;
            buf_addr   <= buf_addr_n;
            buf_data   <= buf_data_n;
            fetch_addr <= fetch_addr_n;
            asm_q      <= asm_n;
            mem_re     <= mem_re_n;
            mem_addr   <= mem_addr_n;
        end
    end
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: scoreboard bench with a variable-latency byte memory model
module tb_rom_fetch_ctrl;
    logic        clk = 1'b0, rst = 1'b0, rom_ce = 1'b0, flush = 1'b0;
    logic [31:0] rom_raddr = '0;
    logic [31:0] rom_rdata, mem_addr;
    logic        stall, mem_re, mem_rvalid;
    logic [7:0]  mem_rdata;
    int          n_cmp = 0, n_bad = 0, lat = 1, cnt = 0, n;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] addr_q[$];
    logic [31:0] word_q[$];

    rom_fetch_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_raddr(rom_raddr),
        .rom_rdata(rom_rdata), .stall(stall), .flush(flush),
        .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (a == 32'h100) return 8'h13;
        if (a >= 32'h101 && a <= 32'h103) return 8'h00;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {mb({a[31:2], 2'd3}), mb({a[31:2], 2'd2}), mb({a[31:2], 2'd1}), mb({a[31:2], 2'd0})};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory answers L cycles after it sees mem_re; it ignores DUT reset on purpose
    always @(posedge clk) begin
        if (mem_re) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= mem_addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else cnt <= cnt - 1;
        end
    end
    assign mem_rvalid = pend && cnt == 0;
    assign mem_rdata  = mb(paddr);

    always @(negedge clk) begin
        if (rst && mem_re) begin
            check("one_outstanding", 64'(pend), 64'd0);
            check("re_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
    end

    task automatic push_addrs(input logic [31:0] a, input int k);
        for (int i = 0; i < k; i++) addr_q.push_back({a[31:2], 2'(i)});
    endtask

    task automatic wait_stall_low(output int c);
        c = 0;
        while (stall && c < 200) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_cyc, input logic miss);
        if (miss) push_addrs(a, 4);
        word_q.push_back(word_of(a));
        @(posedge clk); #1;
        rom_ce = 1'b1;
        rom_raddr = a;
        @(negedge clk);
        wait_stall_low(n);
        check("latency", 64'(n), 64'(exp_cyc));
        check("rom_rdata", 64'(rom_rdata), 64'(word_q.pop_front()));
    endtask

    task automatic wait_read(input logic [31:0] a);
        int c = 0;
        while (!(mem_re && mem_addr == a) && c < 200) begin
            c++;
            @(negedge clk);
        end
        check("read_seen", 64'(c < 200), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_rdata", 64'(rom_rdata), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_stall_idle", 64'(stall), 64'd0);
        rom_ce = 1'b1;
        #1 check("rst_stall_ce", 64'(stall), 64'd1);
        rom_ce = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        lat = 1;
        fetch(32'h100, 9, 1'b1);
        fetch(32'h100, 0, 1'b0);

        lat = 3;
        fetch(32'h104, 17, 1'b1);
        fetch(32'h100, 17, 1'b1);

        push_addrs(32'h104, 3);
        @(posedge clk); #1 rom_raddr = 32'h104;
        @(negedge clk);
        wait_read(32'h106);
        push_addrs(32'h200, 4);
        @(posedge clk); #1 rom_raddr = 32'h200;
        @(negedge clk);
        wait_stall_low(n);
        check("redirect_latency", 64'(n), 64'd20);
        check("redirect_data", 64'(rom_rdata), 64'(word_of(32'h200)));
        fetch(32'h104, 17, 1'b1);

        lat = 1;
        push_addrs(32'h300, 4);
        @(posedge clk); #1 rom_raddr = 32'h300;
        @(negedge clk);
        wait_read(32'h303);
        @(posedge clk); #1 flush = 1'b1;
        push_addrs(32'h300, 4);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_miss", 64'(stall), 64'd1);
        wait_stall_low(n);
        check("flush_refetch_latency", 64'(n), 64'd9);
        check("flush_refetch_data", 64'(rom_rdata), 64'(word_of(32'h300)));

        lat = 3;
        push_addrs(32'h400, 1);
        @(posedge clk); #1 rom_raddr = 32'h400;
        @(negedge clk);
        wait_read(32'h400);
        @(posedge clk); #2;
        rst = 1'b0;
        rom_ce = 1'b0;
        #1;
        check("async_mem_re", 64'(mem_re), 64'd0);
        check("async_mem_addr", 64'(mem_addr), 64'd0);
        check("async_rdata", 64'(rom_rdata), 64'd0);
        check("async_stall", 64'(stall), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        n = 0;
        @(negedge clk);
        while (pend && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("stray_done", 64'(pend), 64'd0);
        check("stray_ignored", 64'(rom_rdata), 64'd0);
        fetch(32'h400, 17, 1'b1);
        check("addr_q_drained", 64'(addr_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction fetch controller between the core's ROM port (pc_reg / IF_ID side) and a byte-wide external instruction memory. Each 32-bit instruction is assembled from four little-endian byte reads, one outstanding read at a time. The last fetched word is held in a one-entry buffer and served combinationally on a hit. On a miss the controller raises `stall` to freeze the PC until the word is valid.

## Interface
Parameters:
- `ADDR_W`, 32, width of core and memory byte addresses.
- `INST_W`, 32, instruction width; fixed at 4 bytes.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rom_ce`  in  1  core fetch enable.
- `rom_raddr`  in  ADDR_W  core fetch address; bits [1:0] ignored.
- `rom_rdata`  out  INST_W  instruction; equals buffer data.
- `stall`  out  1  high while `rom_ce` and no hit; PC must hold.
- `flush`  in  1  single-cycle pulse; invalidates the buffer and aborts any fetch.
- `mem_re`  out  1  one-cycle byte read strobe.
- `mem_addr`  out  ADDR_W  byte address for `mem_re`.
- `mem_rdata`  in  8  returned byte.
- `mem_rvalid`  in  1  `mem_rdata` valid; arrives ≥1 cycle after `mem_re`.

## Operation
- Buffer: `buf_valid`, `buf_addr` (word address, ADDR_W-2 bits), `buf_data` (32 bits).
- Hit is `rom_ce && buf_valid && rom_raddr[ADDR_W-1:2]==buf_addr && !flush`.
- `stall = rom_ce && !hit`.
- `rom_rdata = buf_data` regardless of hit.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on `rom_ce && !hit`, latch word address into `fetch_addr`, clear `idx` and `abort`, go to REQ.
  - REQ: if `abort`, go to IDLE with no read. Otherwise assert `mem_re` with `mem_addr = {fetch_addr, idx}` and go to WAIT.
  - WAIT: on `mem_rvalid`, write `mem_rdata` into `asm[8*idx+7 : 8*idx]`.
    - If `abort`: discard the byte, go to IDLE.
    - Else if `idx==3`: load buffer with `{fetch_addr, assembled word}`, set `buf_valid`, go to IDLE.
    - Else: `idx+1`, go to REQ.
- `abort` sets in REQ/WAIT when any of these holds; it stays set until IDLE:
  - `flush`;
  - `!rom_ce`;
  - `rom_raddr` word address ≠ `fetch_addr`.
- `flush` also clears `buf_valid` in any state.
- Flush-vs-load priority: if `flush` coincides with the final byte's `mem_rvalid`, the word is discarded and `buf_valid` is 0 next cycle. Flush wins.
- `mem_rvalid` outside WAIT is ignored.
- Only one read is outstanding; a new read is never issued before the pending `mem_rvalid`.

## Timing
- Reset values (async, on `rst`=0):
  - state IDLE; `idx`, `abort`, `buf_valid` all 0;
  - `buf_addr`, `buf_data`, `fetch_addr`, `asm` all 0;
  - `mem_re`=0, `mem_addr`=0;
  - `rom_rdata`=0; `stall` = `rom_ce`.
- `mem_re` and `mem_addr` are registered Moore outputs of REQ; `mem_addr` holds its last value otherwise.
- Miss latency with memory latency L (`mem_rvalid` L cycles after `mem_re`) is 1+4(L+1) cycles, from the miss cycle to the first hit cycle. For L=1 that is 9 cycles.
- Hit: 0 cycles; `stall` is low in the same cycle.
- Reset mid-fetch: all state cleared immediately. A late `mem_rvalid` after reset release is ignored because the FSM is in IDLE.
- Abort in WAIT: the FSM returns to IDLE the cycle after the pending `mem_rvalid`. The new miss starts REQ one cycle later.

## Structure
- Shared defines header holds:
  - FSM state encodings (2 bits);
  - `INST_W`;
  - byte-lane count (4).
- `ADDR_W` stays a module parameter.
- Single module; no sub-module needed. Buffer, assembler and FSM stay in one always block set plus a combinational hit/stall block.

## Test plan
- Cold miss, L=1: `rom_raddr`=0x100, bytes 0x13,0x00,0x00,0x00.
  - `mem_addr` sequence 0x100..0x103.
  - `stall` high for 9 cycles, then `rom_rdata`=0x00000013.
- Hit after fill: same address again → `stall`=0 the same cycle, no `mem_re`.
- Sequential 0x100, 0x104 with L=3: second word misses, takes 17 cycles, and replaces the buffer.
- Redirect mid-fetch: address changes 0x104→0x200 during WAIT of byte 2.
  - Byte-2 response is discarded; no buffer write for 0x104.
  - Next `mem_addr`=0x200 only after the pending `mem_rvalid`.
- Flush on the final byte's `mem_rvalid`: `buf_valid`=0 next cycle; re-request of the same address misses again.
- Async reset asserted in WAIT with `mem_rvalid` 1 cycle after release:
  - outputs go to reset values immediately;
  - the stray response is ignored;
  - the next request starts a clean fetch.
